// File: rtl/proximity_alarm_if.sv
// Handshake bundle between the ranging stage, the proximity alarm and the output stage.
// The master drives readings and operator controls; the slave returns alarm status.
interface proximity_alarm_if #(
   parameter int DIST_W = 9
);
   logic              dist_valid;
   logic [DIST_W-1:0] dist_cm;
   logic              arm;
   logic              ack;
   logic              alarm;
   logic              buzzer;
   logic [DIST_W-1:0] avg_cm;
   logic [2:0]        state;

   modport master (
      output dist_valid, dist_cm, arm, ack,
      input  alarm, buzzer, avg_cm, state
   );

   modport slave (
      input  dist_valid, dist_cm, arm, ack,
      output alarm, buzzer, avg_cm, state
   );
endinterface

// File: rtl/proximity_alarm.sv
// Proximity alarm: 4-tap moving average of distance readings, near/far hysteresis with
// consecutive-sample confirmation, and an armed/alarm/hold sequencer driving LED and buzzer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// DISARMED   | arm low; everything idle
// ARMED      | watching for the first near average
// PENDING    | counting consecutive near averages toward CONFIRM
// ALARM      | target confirmed near; LED on, buzzer beeping
// HOLD       | target went far; LED held on until the hold timer expires
module proximity_alarm #(
   parameter int CLK_HZ  = 50000000,
   parameter int DIST_W  = 9,
   parameter int NEAR_CM = 20,
   parameter int FAR_CM  = 25,
   parameter int CONFIRM = 3,
   parameter int HOLD_MS = 2000,
   parameter int BEEP_HZ = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   proximity_alarm_if.slave bus
);

   localparam int     SUM_W    = DIST_W + 2;
   localparam longint HOLD_CYC = (longint'(HOLD_MS) * longint'(CLK_HZ)) / 1000;
   localparam int     TMR_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int     HALF     = CLK_HZ / (2 * BEEP_HZ);
   localparam int     PH_W     = $clog2(HALF + 1);

   localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
   localparam logic [PH_W-1:0]   HALF_V    = PH_W'(HALF);
   localparam logic [DIST_W-1:0] NEAR_V    = DIST_W'(NEAR_CM);
   localparam logic [DIST_W-1:0] FAR_V     = DIST_W'(FAR_CM);
   localparam logic [3:0]        CONF_V    = 4'(CONFIRM);

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_ARMED    = 3'd1,
      ST_PENDING  = 3'd2,
      ST_ALARM    = 3'd3,
      ST_HOLD     = 3'd4
   } state_t;

   logic [3:0][DIST_W-1:0] taps_q, taps_d;
   logic [SUM_W-1:0]       sum_q, sum_d;
   logic [DIST_W-1:0]      avg_q, avg_d;
   logic                   avg_valid_q, avg_valid_d;
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [PH_W-1:0]        ph_q, ph_d;
   logic                   buz_q, buz_d;
   logic                   alarm_q, alarm_d;

   logic accept;
   logic near;
   logic far;

   // Zero means "no echo" and must not disturb the filter.
   assign accept = bus.dist_valid && (bus.dist_cm != '0);

   always_comb begin
      taps_d      = taps_q;
      sum_d       = sum_q;
      avg_valid_d = 1'b0;
      if (accept) begin
         taps_d      = {taps_q[2:0], bus.dist_cm};
         sum_d       = sum_q + SUM_W'(bus.dist_cm) - SUM_W'(taps_q[3]);
         avg_valid_d = 1'b1;
      end
      avg_d = sum_d[SUM_W-1:2];
   end

   assign near = avg_valid_q && (avg_q < NEAR_V);
   assign far  = avg_valid_q && (avg_q >= FAR_V);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      if (!bus.arm) begin
         state_d = ST_DISARMED;
         cnt_d   = '0;
         tmr_d   = '0;
      end else if (bus.ack && ((state_q == ST_ALARM) || (state_q == ST_HOLD))) begin
         state_d = ST_ARMED;
         cnt_d   = '0;
         tmr_d   = '0;
      end else begin
         case (state_q)
            ST_DISARMED: state_d = ST_ARMED;
            ST_ARMED: begin
               if (near) begin
                  if (CONF_V <= 4'd1) begin
                     state_d = ST_ALARM;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_PENDING;
                     cnt_d   = 4'd1;
                  end
               end
            end
            ST_PENDING: begin
               if (near) begin
                  if ((cnt_q + 4'd1) >= CONF_V) begin
                     state_d = ST_ALARM;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else if (far) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
               end
            end
            ST_ALARM: begin
               if (far) begin
                  state_d = ST_HOLD;
                  tmr_d   = HOLD_LOAD;
               end
            end
            ST_HOLD: begin
               // A returning target beats a coincident timer expiry.
               if (near) begin
                  state_d = ST_ALARM;
                  tmr_d   = '0;
               end else if (tmr_q == '0) begin
                  state_d = ST_ARMED;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            default: begin
               state_d = ST_DISARMED;
               cnt_d   = '0;
               tmr_d   = '0;
            end
         endcase
      end
   end

   // Buzzer phase restarts high on every entry into ALARM, including re-entry from HOLD.
   always_comb begin
      ph_d    = '0;
      buz_d   = 1'b0;
      alarm_d = (state_d == ST_ALARM) || (state_d == ST_HOLD);
      if (state_d == ST_ALARM) begin
         if (state_q != ST_ALARM) begin
            ph_d  = PH_W'(1);
            buz_d = 1'b1;
         end else if (ph_q == HALF_V) begin
            ph_d  = PH_W'(1);
            buz_d = ~buz_q;
         end else begin
            ph_d  = ph_q + PH_W'(1);
            buz_d = buz_q;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         taps_q      <= '1;
         sum_q       <= {{DIST_W{1'b1}}, 2'b00};
         avg_q       <= '1;
         avg_valid_q <= 1'b0;
         state_q     <= ST_DISARMED;
         cnt_q       <= '0;
         tmr_q       <= '0;
         ph_q        <= '0;
         buz_q       <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         taps_q      <= taps_d;
         sum_q       <= sum_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         ph_q        <= ph_d;
         buz_q       <= buz_d;
         alarm_q     <= alarm_d;
      end
   end

   assign bus.alarm  = alarm_q;
   assign bus.buzzer = buz_q;
   assign bus.avg_cm = avg_q;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_proximity_alarm.sv
// Bench for proximity_alarm: directed scenarios plus randomized readings, checked against
// an event-level model (sample queue, near-count, timestamped hold and beep phase).
module tb_proximity_alarm;

   localparam int CLK_HZ   = 1000;
   localparam int DIST_W   = 9;
   localparam int NEAR     = 20;
   localparam int FAR      = 25;
   localparam int CONF     = 3;
   localparam int HOLD_MS  = 5;
   localparam int BEEP_HZ  = 100;
   localparam int HOLD_CYC = HOLD_MS * CLK_HZ / 1000;
   localparam int HALF     = CLK_HZ / (2 * BEEP_HZ);

   localparam int S_DIS = 0, S_ARM = 1, S_PEN = 2, S_ALM = 3, S_HLD = 4;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   proximity_alarm_if #(.DIST_W(DIST_W)) bus ();

   proximity_alarm #(
      .CLK_HZ(CLK_HZ), .DIST_W(DIST_W), .NEAR_CM(NEAR), .FAR_CM(FAR),
      .CONFIRM(CONF), .HOLD_MS(HOLD_MS), .BEEP_HZ(BEEP_HZ)
   ) dut (
      .clock(clock),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   int checks = 0;
   int errors = 0;

   // Model: last four accepted readings, near count, absolute edge of hold expiry, alarm start edge.
   int m_taps[$];
   int m_state;
   int m_cnt;
   int m_hold_exit;
   int m_alarm_start;
   int mid_alarm_obs;
   int mid_alarm_exp;

   function automatic int m_avg();
      int s = 0;
      foreach (m_taps[i]) s += m_taps[i];
      return s / 4;
   endfunction

   function automatic void m_reset();
      m_taps = {511, 511, 511, 511};
      m_state = S_DIS;
      m_cnt = 0;
      m_hold_exit = 0;
      m_alarm_start = 0;
   endfunction

   function automatic void m_push(int d);
      if (d != 0) begin
         m_taps.push_front(d);
         void'(m_taps.pop_back());
      end
   endfunction

   function automatic void m_sync(int s);
      if (m_state == S_HLD && s >= m_hold_exit) m_state = S_ARM;
   endfunction

   function automatic void m_enter_alarm(int t);
      m_state = S_ALM;
      m_cnt = 0;
      m_alarm_start = t;
   endfunction

   function automatic int m_alarm_lvl();
      return (m_state == S_ALM || m_state == S_HLD) ? 1 : 0;
   endfunction

   function automatic int m_buz(int s);
      if (m_state != S_ALM) return 0;
      return (((s - m_alarm_start) / HALF) % 2 == 0) ? 1 : 0;
   endfunction

   // Applies what the sequencer does at edge t given an average (if any) and ack.
   function automatic void m_eval(int t, bit av, int avg, bit ack);
      bit is_near = av && (avg < NEAR);
      bit is_far  = av && (avg >= FAR);
      m_sync(t - 1);
      if (ack && (m_state == S_ALM || m_state == S_HLD)) begin
         m_state = S_ARM;
         m_cnt = 0;
         return;
      end
      case (m_state)
         S_ARM, S_PEN: begin
            if (is_near) begin
               m_cnt++;
               if (m_cnt >= CONF) m_enter_alarm(t);
               else m_state = S_PEN;
            end else if (is_far) begin
               m_state = S_ARM;
               m_cnt = 0;
            end
         end
         S_ALM: if (is_far) begin
            m_state = S_HLD;
            m_hold_exit = t + HOLD_CYC;
         end
         S_HLD: begin
            if (is_near) m_enter_alarm(t);
            else if (t >= m_hold_exit) m_state = S_ARM;
         end
         default: ;
      endcase
   endfunction

   function automatic int rand_dist();
      int r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r <= 3) return $urandom_range(1, 19);
      if (r <= 5) return $urandom_range(20, 24);
      return $urandom_range(25, 300);
   endfunction

   task automatic send(input int d);
      int e, t;
      @(negedge clock);
      bus.dist_valid = 1'b1;
      bus.dist_cm    = DIST_W'(d);
      @(negedge clock);
      bus.dist_valid = 1'b0;
      e = edge_cnt;
      m_sync(e);
      m_push(d);
      mid_alarm_obs = int'(bus.alarm);
      mid_alarm_exp = m_alarm_lvl();
      @(negedge clock);
      t = edge_cnt;
      m_eval(t, d != 0, m_avg(), 1'b0);
      m_sync(t);
   endtask

   task automatic tick();
      @(negedge clock);
      m_sync(edge_cnt);
   endtask

   task automatic pulse(input bit a, input bit arm_v);
      int t;
      @(negedge clock);
      bus.ack = a;
      bus.arm = arm_v;
      @(negedge clock);
      bus.ack = 1'b0;
      t = edge_cnt;
      if (!arm_v) begin
         m_state = S_DIS;
         m_cnt = 0;
      end else begin
         m_eval(t, 1'b0, 0, a);
      end
      m_sync(t);
   endtask

   task automatic set_arm();
      @(negedge clock);
      bus.arm = 1'b1;
      @(negedge clock);
      if (m_state == S_DIS) m_state = S_ARM;
   endtask

   task automatic test_reset();
      bus.dist_valid = 1'b0;
      bus.dist_cm = '0;
      bus.arm = 1'b0;
      bus.ack = 1'b0;
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(negedge clock);
      checks++; if (bus.avg_cm !== 9'd511) begin errors++; $display("FAIL reset_avg got %0d exp 511", bus.avg_cm); end
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
      checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %0b exp 0", bus.alarm); end
      checks++; if (bus.buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got %0b exp 0", bus.buzzer); end
      rst_n = 1'b1;
      repeat (2) tick();
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL disarmed_hold got %0d exp 0", bus.state); end
   endtask

   task automatic test_fill();
      set_arm();
      checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL arm_enter got %0d exp 1", bus.state); end
      for (int i = 0; i < 8; i++) begin
         send(100);
         checks++; if (bus.avg_cm !== DIST_W'(m_avg())) begin errors++; $display("FAIL fill_avg i=%0d got %0d exp %0d", i, bus.avg_cm, m_avg()); end
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL fill_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
      end
      checks++; if (bus.avg_cm !== 9'd100) begin errors++; $display("FAIL fill_avg100 got %0d exp 100", bus.avg_cm); end
      checks++; if (bus.state !== 3'd1 || bus.alarm !== 1'b0) begin errors++; $display("FAIL fill_end state=%0d alarm=%0b exp 1/0", bus.state, bus.alarm); end
   endtask

   task automatic test_alarm();
      for (int i = 0; i < 6; i++) begin
         send(10);
         checks++; if (bus.avg_cm !== DIST_W'(m_avg())) begin errors++; $display("FAIL near_avg i=%0d got %0d exp %0d", i, bus.avg_cm, m_avg()); end
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL near_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
         checks++; if (mid_alarm_obs != mid_alarm_exp) begin errors++; $display("FAIL alarm_latency i=%0d got %0d exp %0d", i, mid_alarm_obs, mid_alarm_exp); end
      end
      checks++; if (bus.state !== 3'd3 || bus.alarm !== 1'b1 || bus.buzzer !== 1'b1) begin
         errors++; $display("FAIL alarm_entry state=%0d alarm=%0b buz=%0b exp 3/1/1", bus.state, bus.alarm, bus.buzzer);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++; if (bus.buzzer !== 1'(m_buz(edge_cnt))) begin errors++; $display("FAIL buzzer k=%0d got %0b exp %0d", k, bus.buzzer, m_buz(edge_cnt)); end
      end
   endtask

   task automatic test_hold();
      int n = 0;
      int hold_seen;
      while (m_state != S_HLD && n < 8) begin
         send(100);
         n++;
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL far_state n=%0d got %0d exp %0d", n, bus.state, m_state); end
      end
      checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL hold_entry got %0d exp 4", bus.state); end
      hold_seen = (bus.state === 3'd4) ? 1 : 0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (bus.state === 3'd4) hold_seen++;
         checks++; if (bus.alarm !== 1'(m_alarm_lvl()) || bus.buzzer !== 1'b0) begin
            errors++; $display("FAIL hold_out k=%0d alarm=%0b buz=%0b exp %0d/0", k, bus.alarm, bus.buzzer, m_alarm_lvl());
         end
      end
      checks++; if (hold_seen != HOLD_CYC) begin errors++; $display("FAIL hold_len got %0d exp %0d", hold_seen, HOLD_CYC); end
      checks++; if (bus.state !== 3'd1 || bus.alarm !== 1'b0) begin errors++; $display("FAIL hold_exit state=%0d alarm=%0b exp 1/0", bus.state, bus.alarm); end
   endtask

   task automatic test_pending_held();
      for (int i = 0; i < 5; i++) begin
         send(10);
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL pend_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
      end
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL pend_two got %0d exp 2", bus.state); end
      send(58);
      checks++; if (bus.avg_cm !== 9'd22 || bus.state !== 3'd2) begin errors++; $display("FAIL neutral avg=%0d state=%0d exp 22/2", bus.avg_cm, bus.state); end
      send(1);
      checks++; if (bus.state !== 3'd3 || bus.alarm !== 1'b1) begin errors++; $display("FAIL count_held state=%0d alarm=%0b exp 3/1", bus.state, bus.alarm); end
   endtask

   task automatic test_ack();
      pulse(1'b1, 1'b0);
      checks++; if (bus.state !== 3'd0 || bus.alarm !== 1'b0) begin errors++; $display("FAIL arm_beats_ack state=%0d alarm=%0b exp 0/0", bus.state, bus.alarm); end
      set_arm();
      pulse(1'b1, 1'b1);
      checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL ack_ignored got %0d exp 1", bus.state); end
      for (int i = 0; i < 3; i++) begin
         send(10);
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL realarm_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
      end
      checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL realarm got %0d exp 3", bus.state); end
      pulse(1'b1, 1'b1);
      checks++; if (bus.state !== 3'd1 || bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_clear state=%0d alarm=%0b exp 1/0", bus.state, bus.alarm); end
      send(10);
      send(10);
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL ack_recount got %0d exp 2", bus.state); end
      send(10);
      checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL ack_realarm got %0d exp 3", bus.state); end
   endtask

   task automatic test_back_to_back();
      int v[12];
      bit pav = 1'b0;
      int pavg = 0;
      int s;
      foreach (v[i]) v[i] = rand_dist();
      @(negedge clock);
      bus.dist_valid = 1'b1;
      bus.dist_cm = DIST_W'(v[0]);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         s = edge_cnt;
         m_eval(s, pav, pavg, 1'b0);
         m_sync(s);
         m_push(v[i]);
         pav = (v[i] != 0);
         pavg = m_avg();
         checks++; if (bus.avg_cm !== DIST_W'(m_avg())) begin errors++; $display("FAIL b2b_avg i=%0d got %0d exp %0d", i, bus.avg_cm, m_avg()); end
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL b2b_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
         if (i == 11) bus.dist_valid = 1'b0;
         else bus.dist_cm = DIST_W'(v[i+1]);
      end
      @(negedge clock);
      s = edge_cnt;
      m_eval(s, pav, pavg, 1'b0);
      m_sync(s);
      checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL b2b_tail got %0d exp %0d", bus.state, m_state); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int op = $urandom_range(0, 9);
         if (op == 0) pulse(1'b1, 1'b1);
         else if (op == 1) repeat ($urandom_range(1, 4)) tick();
         else send(rand_dist());
         checks++; if (bus.avg_cm !== DIST_W'(m_avg())) begin errors++; $display("FAIL rnd_avg i=%0d got %0d exp %0d", i, bus.avg_cm, m_avg()); end
         checks++; if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state i=%0d got %0d exp %0d", i, bus.state, m_state); end
         checks++; if (bus.alarm !== 1'(m_alarm_lvl())) begin errors++; $display("FAIL rnd_alarm i=%0d got %0b exp %0d", i, bus.alarm, m_alarm_lvl()); end
         checks++; if (bus.buzzer !== 1'(m_buz(edge_cnt))) begin errors++; $display("FAIL rnd_buzzer i=%0d got %0b exp %0d", i, bus.buzzer, m_buz(edge_cnt)); end
      end
   endtask

   task automatic test_reset_hold();
      int n = 0;
      while (m_state != S_ALM && n < 12) begin send(5); n++; end
      while (m_state != S_HLD && n < 20) begin send(300); n++; end
      checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL pre_reset_hold got %0d exp 4", bus.state); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.alarm !== 1'b0 || bus.avg_cm !== 9'd511) begin errors++; $display("FAIL async_reset alarm=%0b avg=%0d exp 0/511", bus.alarm, bus.avg_cm); end
      checks++; if (bus.state !== 3'd0 || bus.buzzer !== 1'b0) begin errors++; $display("FAIL async_reset2 state=%0d buz=%0b exp 0/0", bus.state, bus.buzzer); end
      @(negedge clock);
      rst_n = 1'b1;
      m_reset();
      @(negedge clock);
      m_state = S_ARM;
      checks++; if (bus.state !== 3'(m_state) || bus.avg_cm !== 9'd511) begin errors++; $display("FAIL post_reset state=%0d avg=%0d exp 1/511", bus.state, bus.avg_cm); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_alarm();
      test_hold();
      test_pending_held();
      test_ack();
      test_back_to_back();
      test_random();
      test_reset_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/proximity_alarm.md
# proximity_alarm

Downstream consumer of the ultrasonic ranging stage's distance output. Filters each new centimetre reading with a 4-sample moving average and applies near/far hysteresis plus a consecutive-sample confirmation. Runs an armed/alarm/hold state machine that drives the alarm LED level and a gated buzzer square wave. Sits between the ranging stage and the display/servo/LED output stage.

## Interface
- CLK_HZ, 50000000, clock frequency in Hz
- DIST_W, 9, distance width in cm (0..511)
- NEAR_CM, 20, average strictly below this counts as "near"
- FAR_CM, 25, average at or above this counts as "far" (must be > NEAR_CM)
- CONFIRM, 3, consecutive near averages needed to raise the alarm (1..15)
- HOLD_MS, 2000, alarm hold time after the target goes far
- BEEP_HZ, 4, buzzer square-wave frequency

- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dist_valid  in  1  one-cycle strobe: a new reading is on dist_cm
- dist_cm  in  DIST_W  distance in cm; 0 means "no echo"
- arm  in  1  level; 0 forces DISARMED
- ack  in  1  one-cycle strobe; clears ALARM/HOLD
- alarm  out  1  high in ALARM and HOLD
- buzzer  out  1  square wave at BEEP_HZ while in ALARM, else 0
- avg_cm  out  DIST_W  current 4-sample average
- state  out  3  0 DISARMED, 1 ARMED, 2 PENDING, 3 ALARM, 4 HOLD

## Operation
- Reset values:
  - All four filter taps = 2^DIST_W-1, so avg_cm = 511 at default width.
  - Sum = 4*(2^DIST_W-1).
  - state = DISARMED; alarm = 0; buzzer = 0; confirm counter = 0; hold timer = 0.
- Filter:
  - On dist_valid with dist_cm != 0, shift the sample into the 4-tap buffer and update the running sum: sum + new - oldest.
  - The sum is DIST_W+2 bits and never overflows. avg_cm = sum >> 2 (truncating).
  - The filter generates a one-cycle internal avg_valid pulse.
  - dist_cm = 0 is discarded: no shift and no avg_valid.
- Classification on avg_valid: near if avg < NEAR_CM; far if avg >= FAR_CM; otherwise neutral.
- FSM, evaluated only on avg_valid unless noted:
  - DISARMED: arm=1 -> ARMED. This check runs every cycle, not only on avg_valid.
  - ARMED: near -> PENDING with count = 1. If CONFIRM = 1, near goes directly to ALARM.
  - PENDING:
    - near -> count+1; when count reaches CONFIRM -> ALARM.
    - far -> ARMED, count cleared.
    - neutral -> stay, count held.
  - ALARM: far -> HOLD, hold timer loaded with HOLD_MS*CLK_HZ/1000 - 1. near/neutral -> stay.
  - HOLD:
    - The timer decrements every cycle.
    - near -> ALARM, timer cleared.
    - Timer reaching 0 -> ARMED.
    - If near and expiry coincide, near wins.
- ack (any cycle): in ALARM or HOLD -> ARMED, count and timer cleared. A target that stays near re-alarms after CONFIRM more averages. ack is ignored in the other states.
- arm=0 (any cycle, from any state) -> DISARMED next edge. This has top priority over ack and avg_valid.
- Buzzer:
  - The phase counter and buzzer output are set to 1 on entry to ALARM.
  - Buzzer toggles every CLK_HZ/(2*BEEP_HZ) cycles while in ALARM.
  - Buzzer is forced to 0 in every other state.
- Filter taps are not cleared by arm or ack; only rst_n clears them.

## Timing
- avg_cm updates 1 cycle after the accepted dist_valid edge.
- state/alarm update 1 cycle after that: alarm rises 2 cycles after the CONFIRM-th qualifying strobe.
- arm=0 -> state=DISARMED and alarm=0 after 1 edge.
- ack -> alarm=0 after 1 edge.
- HOLD lasts exactly HOLD_MS*CLK_HZ/1000 cycles, measured from entry into HOLD to the first cycle in ARMED.
- rst_n assertion mid-operation clears all state immediately and asynchronously. Outputs are at reset values while rst_n = 0.
- Back-to-back dist_valid every cycle is legal; each accepted sample produces its own avg_valid.

## Test plan
- Sim params: CLK_HZ=1000, HOLD_MS=5, BEEP_HZ=100.
- Reset, arm=1, feed 8 samples of 100 cm -> avg_cm=100, state=ARMED, alarm=0.
- arm=1, feed 10 cm strobes -> the running average falls below 20 only on the 4th strobe, which counts as near #1. After near #3 (the 6th strobe), alarm=1 two cycles later and buzzer=1, toggling every 5 cycles.
- In ALARM, feed 100 cm until avg >= 25 -> state=HOLD, alarm stays 1 for exactly 5 cycles, then state=ARMED and alarm=0.
- PENDING with 2 near averages, then a neutral average (22 cm), then 1 near -> alarm raised: the count was held, not reset.
- In ALARM, pulse ack together with arm=0 -> state=DISARMED (arm wins). Separately, ack alone -> ARMED; with the target still near, it re-alarms after 3 near averages.
- Interleave dist_cm=0 strobes -> avg_cm and state are unchanged. Assert rst_n=0 mid-HOLD -> alarm=0, avg_cm=511 immediately.
